// File: rtl/busarb_if.sv
// ECO32-style bus port: request, direction, size, address, write data going one way;
// read data and wait coming back. The master drives the request; the slave answers.
interface busarb_if;
  logic        en;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wt;

  modport master (output en, wr, size, addr, wdata, input rdata, wt);
  modport slave  (input en, wr, size, addr, wdata, output rdata, wt);
endinterface

// File: rtl/busarb.sv
// Two-master arbiter for one bus slave port. The grant is registered, stays with the
// last owner when the bus goes quiet, and is forced over after MAX_RUN completions.
module busarb #(
  parameter int PRIO    = 0,
  parameter int MAX_RUN = 4
) (
  input  logic      clk,
  input  logic      reset,
  busarb_if.slave   m0,
  busarb_if.slave   m1,
  busarb_if.master  s,
  output logic [1:0] gnt
);

  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;

  logic   cur_en;
  logic   oth_en;
  state_t oth_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    cur_en    = 1'b0;
    oth_en    = 1'b0;
    oth_state = IDLE;
    if (state_q == G0) begin
      cur_en    = m0.en;
      oth_en    = m1.en;
      oth_state = G1;
    end else if (state_q == G1) begin
      cur_en    = m1.en;
      oth_en    = m0.en;
      oth_state = G0;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        run_d = '0;
        if (m0.en && m1.en)
          state_d = (PRIO != 0) ? G1 : G0;
        else if (m0.en)
          state_d = G0;
        else if (m1.en)
          state_d = G1;
      end
      G0, G1: begin
        if (cur_en && !s.wt) begin
          // The counter holds completions-1 while the other side waits, so the
          // completion that would make it MAX_RUN hands the bus over at that edge.
          if (oth_en) begin
            if (run_q == RUN_LAST) begin
              state_d = oth_state;
              run_d   = '0;
            end else begin
              run_d = run_q + RW'(1);
            end
          end else begin
            run_d = '0;
          end
        end else if (!cur_en && oth_en) begin
          state_d = oth_state;
          run_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    s.en     = 1'b0;
    s.wr     = 1'b0;
    s.size   = 2'b00;
    s.addr   = 32'h0;
    s.wdata  = 32'h0;
    m0.wt    = 1'b1;
    m1.wt    = 1'b1;
    gnt      = 2'b00;
    unique case (state_q)
      G0: begin
        s.en    = m0.en;
        s.wr    = m0.wr;
        s.size  = m0.size;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
        m0.wt   = s.wt;
        gnt     = 2'b01;
      end
      G1: begin
        s.en    = m1.en;
        s.wr    = m1.wr;
        s.size  = m1.size;
        s.addr  = m1.addr;
        s.wdata = m1.wdata;
        m1.wt   = s.wt;
        gnt     = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;

endmodule

// File: tb/tb_busarb.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle against
// an ownership/streak model of the arbitration rules.
module tb_busarb;
  localparam int PRIO    = 0;
  localparam int MAX_RUN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        s_wt;
  logic [31:0] s_rdata;
  logic [1:0]  gnt, gnt_b;

  int checks = 0;
  int errors = 0;
  int owner  = -1;
  int streak = 0;
  int cnt;

  busarb_if m0_if (), m1_if (), s_if ();
  busarb_if m0b_if (), m1b_if (), sb_if ();

  assign m0_if.en = en[0];    assign m0_if.wr = wr[0];    assign m0_if.size = size[0];
  assign m0_if.addr = addr[0]; assign m0_if.wdata = wdata[0];
  assign m1_if.en = en[1];    assign m1_if.wr = wr[1];    assign m1_if.size = size[1];
  assign m1_if.addr = addr[1]; assign m1_if.wdata = wdata[1];
  assign s_if.wt = s_wt;      assign s_if.rdata = s_rdata;

  assign m0b_if.en = en[0];    assign m0b_if.wr = wr[0];    assign m0b_if.size = size[0];
  assign m0b_if.addr = addr[0]; assign m0b_if.wdata = wdata[0];
  assign m1b_if.en = en[1];    assign m1b_if.wr = wr[1];    assign m1b_if.size = size[1];
  assign m1b_if.addr = addr[1]; assign m1b_if.wdata = wdata[1];
  assign sb_if.wt = s_wt;      assign sb_if.rdata = s_rdata;

  busarb #(.PRIO(PRIO), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if), .gnt(gnt)
  );

  busarb #(.PRIO(1), .MAX_RUN(MAX_RUN)) dut_p1 (
    .clk(clk), .reset(reset), .m0(m0b_if), .m1(m1b_if), .s(sb_if), .gnt(gnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        e_en, e_wr;
    logic [1:0]  e_size, e_gnt;
    logic [31:0] e_addr, e_wdata;
    logic        e_wt0, e_wt1;
    e_en = 1'b0; e_wr = 1'b0; e_size = 2'b00; e_addr = 32'h0; e_wdata = 32'h0;
    e_wt0 = 1'b1; e_wt1 = 1'b1; e_gnt = 2'b00;
    if (owner >= 0) begin
      e_en    = en[owner];
      e_wr    = wr[owner];
      e_size  = size[owner];
      e_addr  = addr[owner];
      e_wdata = wdata[owner];
      if (owner == 0) e_wt0 = s_wt; else e_wt1 = s_wt;
      e_gnt   = (owner == 0) ? 2'b01 : 2'b10;
    end
    chk("s_en", 32'(s_if.en), 32'(e_en));
    chk("s_wr", 32'(s_if.wr), 32'(e_wr));
    chk("s_size", 32'(s_if.size), 32'(e_size));
    chk("s_addr", s_if.addr, e_addr);
    chk("s_wdata", s_if.wdata, e_wdata);
    chk("m0_wt", 32'(m0_if.wt), 32'(e_wt0));
    chk("m1_wt", 32'(m1_if.wt), 32'(e_wt1));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("m0_rdata", m0_if.rdata, s_rdata);
    chk("m1_rdata", m1_if.rdata, s_rdata);
  endtask

  task automatic model_update();
    int me, ot;
    if (owner < 0) begin
      if (en[0] && en[1]) owner = PRIO;
      else if (en[0])     owner = 0;
      else if (en[1])     owner = 1;
      streak = 0;
    end else begin
      me = owner;
      ot = 1 - owner;
      if (en[me] && !s_wt) begin
        if (en[ot]) begin
          streak++;
          if (streak >= MAX_RUN) begin
            owner  = ot;
            streak = 0;
          end
        end else begin
          streak = 0;
        end
      end else if (!en[me] && en[ot]) begin
        owner  = ot;
        streak = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    check_outputs();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    owner = -1;
    streak = 0;
    #1;
    check_outputs();
    tick();
    reset = 1'b0;
  endtask

  // Runs m0 back-to-back with m1 waiting until m1 holds the grant; n = m0 completions seen.
  task automatic count_until_g1(output int n);
    int i;
    n = 0;
    i = 0;
    #1;
    while (gnt !== 2'b10 && i < 20) begin
      check_outputs();
      if (m0_if.en && !m0_if.wt) n++;
      tick();
      #1;
      i++;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'b00; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    s_wt = 1'b0;
    s_rdata = 32'h0;
    @(negedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_s_en", 32'(s_if.en), 32'h0);
    chk("reset_wt", {30'h0, m1_if.wt, m0_if.wt}, 32'h3);
    check_outputs();
    tick();
    reset = 1'b0;

    // m0 read at 0x100, slave waits two cycles
    en[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'h100; s_wt = 1'b1;
    #1;
    chk("first_req_gnt", 32'(gnt), 32'h0);
    check_outputs();
    tick();
    #1;
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_addr", s_if.addr, 32'h100);
    check_outputs();
    tick();
    step();
    s_wt = 1'b0; s_rdata = 32'h12345678;
    #1;
    chk("first_m0_wt", 32'(m0_if.wt), 32'h0);
    chk("first_rdata", m0_if.rdata, 32'h12345678);
    check_outputs();
    tick();

    // park on m0, then m1 asks two cycles later
    en[0] = 1'b0;
    #1;
    chk("park_gnt", 32'(gnt), 32'h1);
    chk("park_s_en", 32'(s_if.en), 32'h0);
    check_outputs();
    tick();
    step();
    en[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'b01; addr[1] = 32'h2000; wdata[1] = 32'hcafe;
    #1;
    chk("park_req_gnt", 32'(gnt), 32'h1);
    check_outputs();
    tick();
    #1;
    chk("idle_switch_gnt", 32'(gnt), 32'h2);
    check_outputs();
    tick();
    en[1] = 1'b0;
    step();

    // simultaneous request from IDLE, then fairness limit
    do_reset();
    en[0] = 1'b1; en[1] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h40; wr[1] = 1'b0; addr[1] = 32'h80;
    s_wt = 1'b1;
    step();
    #1;
    chk("prio0_gnt", 32'(gnt), 32'h1);
    chk("prio1_gnt", 32'(gnt_b), 32'h2);
    chk("prio0_m1_wt", 32'(m1_if.wt), 32'h1);
    check_outputs();
    tick();
    s_wt = 1'b0;
    count_until_g1(cnt);
    chk("forced_run_len", cnt, 32'(MAX_RUN));
    chk("forced_gnt", 32'(gnt), 32'h2);
    check_outputs();
    tick();
    en[1] = 1'b0;
    step();
    #1;
    chk("return_gnt", 32'(gnt), 32'h1);
    check_outputs();
    tick();

    // asynchronous reset during a stalled m1 write
    en[0] = 1'b0; en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h3000; wdata[1] = 32'h5a5a; s_wt = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    owner = -1;
    streak = 0;
    #1;
    chk("async_s_en", 32'(s_if.en), 32'h0);
    chk("async_wt", {30'h0, m1_if.wt, m0_if.wt}, 32'h3);
    chk("async_gnt", 32'(gnt), 32'h0);
    check_outputs();
    #1;
    reset = 1'b0;
    tick();
    #1;
    chk("post_reset_gnt", 32'(gnt), 32'h2);
    check_outputs();
    tick();

    // m1 aborts mid-transfer while m0 waits
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h44; wdata[0] = 32'h1111;
    step();
    en[1] = 1'b0;
    #1;
    chk("abort_s_en", 32'(s_if.en), 32'h0);
    check_outputs();
    tick();
    #1;
    chk("abort_gnt", 32'(gnt), 32'h1);
    check_outputs();
    tick();
    en[1] = 1'b1; s_wt = 1'b0;
    count_until_g1(cnt);
    chk("abort_run_len", cnt, 32'(MAX_RUN));
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]    = ($urandom_range(0, 9) < 7);
        wr[i]    = 1'($urandom_range(0, 1));
        size[i]  = 2'($urandom_range(0, 2));
        addr[i]  = $urandom;
        wdata[i] = $urandom;
      end
      s_wt    = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
